// File: rtl/data_mem_controller.sv
// Round-robin responder between NUM_CONSUMERS valid/ready requesters and NUM_CHANNELS memory channels.
// Define DMC_WRITE_EN for the read/write path; the default build is read-only (program memory).
module data_mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]  mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0]  mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS],
    output logic [DATA_BITS-1:0]     mem_write_data [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_write_ready
);

    localparam int                PTR_BITS   = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [PTR_BITS:0] NUM_CONS_W = NUM_CONSUMERS[PTR_BITS:0];
    localparam logic [PTR_BITS:0] PTR_ONE    = {{PTR_BITS{1'b0}}, 1'b1};

`ifdef DMC_WRITE_EN
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_READ_WAIT   = 3'd1,
        S_WRITE_WAIT  = 3'd2,
        S_READ_RELAY  = 3'd3,
        S_WRITE_RELAY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_READ_WAIT  = 3'd1,
        S_READ_RELAY = 3'd3
    } state_t;
`endif

    state_t                  state_q [NUM_CHANNELS];
    state_t                  state_d [NUM_CHANNELS];
    logic [PTR_BITS-1:0]     owner_q [NUM_CHANNELS];
    logic [PTR_BITS-1:0]     owner_d [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] claimed_q, claimed_d;
    logic [PTR_BITS-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_CONSUMERS-1:0] req_s;

    logic [NUM_CHANNELS-1:0]  mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]     mem_read_address_q [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     mem_read_address_d [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] consumer_read_ready_q, consumer_read_ready_d;
    logic [DATA_BITS-1:0]     consumer_read_data_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     consumer_read_data_d [NUM_CONSUMERS];

`ifdef DMC_WRITE_EN
    logic [NUM_CHANNELS-1:0]  mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]     mem_write_address_q [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     mem_write_address_d [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     mem_write_data_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     mem_write_data_d [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] consumer_write_ready_q, consumer_write_ready_d;

    assign req_s = consumer_read_valid | consumer_write_valid;
`else
    logic unused_write_s;

    assign req_s = consumer_read_valid;

    // Write-side inputs have no function in the read-only build.
    always_comb begin
        unused_write_s = ^{consumer_write_valid, mem_write_ready};
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            unused_write_s = unused_write_s ^ (^consumer_write_address[i]) ^ (^consumer_write_data[i]);
        end
    end
`endif

    // Arbitration and per-channel next-state / output computation.
    always_comb begin : next_state_comb
        logic [NUM_CONSUMERS-1:0] taken;
        logic                     found;
        logic                     hit;
        logic [PTR_BITS:0]        sum;
        logic [PTR_BITS:0]        wrap;
        logic [PTR_BITS:0]        nxt;
        logic [PTR_BITS-1:0]      cur;
        logic [PTR_BITS-1:0]      pick;

        state_d               = state_q;
        owner_d               = owner_q;
        claimed_d             = claimed_q;
        rr_ptr_d              = rr_ptr_q;
        mem_read_valid_d      = mem_read_valid_q;
        mem_read_address_d    = mem_read_address_q;
        consumer_read_ready_d = consumer_read_ready_q;
        consumer_read_data_d  = consumer_read_data_q;
`ifdef DMC_WRITE_EN
        mem_write_valid_d      = mem_write_valid_q;
        mem_write_address_d    = mem_write_address_q;
        mem_write_data_d       = mem_write_data_q;
        consumer_write_ready_d = consumer_write_ready_q;
`endif
        taken = {NUM_CONSUMERS{1'b0}};
        found = 1'b0;
        hit   = 1'b0;
        sum   = {(PTR_BITS+1){1'b0}};
        wrap  = {(PTR_BITS+1){1'b0}};
        nxt   = {(PTR_BITS+1){1'b0}};
        cur   = {PTR_BITS{1'b0}};
        pick  = {PTR_BITS{1'b0}};

        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
                S_IDLE: begin
                    // Scan from rr_ptr with explicit wrap so non-power-of-two counts work.
                    found = 1'b0;
                    pick  = {PTR_BITS{1'b0}};
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        sum   = {1'b0, rr_ptr_q} + (PTR_BITS+1)'(k);
                        wrap  = sum - NUM_CONS_W;
                        cur   = (sum >= NUM_CONS_W) ? wrap[PTR_BITS-1:0] : sum[PTR_BITS-1:0];
                        hit   = ~found & ~claimed_q[cur] & ~taken[cur] & req_s[cur];
                        pick  = hit ? cur : pick;
                        found = found | hit;
                    end
                    if (found) begin
                        taken[pick]      = 1'b1;
                        claimed_d[pick]  = 1'b1;
                        owner_d[ch]      = pick;
                        nxt              = {1'b0, pick} + PTR_ONE;
                        rr_ptr_d         = (nxt >= NUM_CONS_W) ? {PTR_BITS{1'b0}} : nxt[PTR_BITS-1:0];
                        if (consumer_read_valid[pick]) begin
                            state_d[ch]            = S_READ_WAIT;
                            mem_read_valid_d[ch]   = 1'b1;
                            mem_read_address_d[ch] = consumer_read_address[pick];
                        end else begin
`ifdef DMC_WRITE_EN
                            state_d[ch]             = S_WRITE_WAIT;
                            mem_write_valid_d[ch]   = 1'b1;
                            mem_write_address_d[ch] = consumer_write_address[pick];
                            mem_write_data_d[ch]    = consumer_write_data[pick];
`else
                            state_d[ch] = S_IDLE;
`endif
                        end
                    end else begin
                        state_d[ch] = S_IDLE;
                    end
                end
                S_READ_WAIT: begin
                    if (mem_read_ready[ch]) begin
                        consumer_read_data_d[owner_q[ch]]  = mem_read_data[ch];
                        consumer_read_ready_d[owner_q[ch]] = 1'b1;
                        mem_read_valid_d[ch]               = 1'b0;
                        state_d[ch]                        = S_READ_RELAY;
                    end else begin
                        mem_read_valid_d[ch] = 1'b1;
                    end
                end
                S_READ_RELAY: begin
                    if (!consumer_read_valid[owner_q[ch]]) begin
                        consumer_read_ready_d[owner_q[ch]] = 1'b0;
                        claimed_d[owner_q[ch]]             = 1'b0;
                        state_d[ch]                        = S_IDLE;
                    end else begin
                        consumer_read_ready_d[owner_q[ch]] = 1'b1;
                    end
                end
`ifdef DMC_WRITE_EN
                S_WRITE_WAIT: begin
                    if (mem_write_ready[ch]) begin
                        consumer_write_ready_d[owner_q[ch]] = 1'b1;
                        mem_write_valid_d[ch]               = 1'b0;
                        state_d[ch]                         = S_WRITE_RELAY;
                    end else begin
                        mem_write_valid_d[ch] = 1'b1;
                    end
                end
                S_WRITE_RELAY: begin
                    if (!consumer_write_valid[owner_q[ch]]) begin
                        consumer_write_ready_d[owner_q[ch]] = 1'b0;
                        claimed_d[owner_q[ch]]              = 1'b0;
                        state_d[ch]                         = S_IDLE;
                    end else begin
                        consumer_write_ready_d[owner_q[ch]] = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d[ch] = S_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch]            <= S_IDLE;
                owner_q[ch]            <= {PTR_BITS{1'b0}};
                mem_read_address_q[ch] <= {ADDR_BITS{1'b0}};
            end
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                consumer_read_data_q[i] <= {DATA_BITS{1'b0}};
            end
            claimed_q             <= {NUM_CONSUMERS{1'b0}};
            rr_ptr_q              <= {PTR_BITS{1'b0}};
            mem_read_valid_q      <= {NUM_CHANNELS{1'b0}};
            consumer_read_ready_q <= {NUM_CONSUMERS{1'b0}};
        end else begin
            state_q               <= state_d;
            owner_q               <= owner_d;
            claimed_q             <= claimed_d;
            rr_ptr_q              <= rr_ptr_d;
            mem_read_valid_q      <= mem_read_valid_d;
            mem_read_address_q    <= mem_read_address_d;
            consumer_read_ready_q <= consumer_read_ready_d;
            consumer_read_data_q  <= consumer_read_data_d;
        end
    end

    assign mem_read_valid      = mem_read_valid_q;
    assign mem_read_address    = mem_read_address_q;
    assign consumer_read_ready = consumer_read_ready_q;
    assign consumer_read_data  = consumer_read_data_q;

`ifdef DMC_WRITE_EN
    // Write-path registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                mem_write_address_q[ch] <= {ADDR_BITS{1'b0}};
                mem_write_data_q[ch]    <= {DATA_BITS{1'b0}};
            end
            mem_write_valid_q      <= {NUM_CHANNELS{1'b0}};
            consumer_write_ready_q <= {NUM_CONSUMERS{1'b0}};
        end else begin
            mem_write_valid_q      <= mem_write_valid_d;
            mem_write_address_q    <= mem_write_address_d;
            mem_write_data_q       <= mem_write_data_d;
            consumer_write_ready_q <= consumer_write_ready_d;
        end
    end

    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    assign consumer_write_ready = consumer_write_ready_q;
`else
    assign mem_write_valid      = {NUM_CHANNELS{1'b0}};
    assign mem_write_address    = '{default: {ADDR_BITS{1'b0}}};
    assign mem_write_data       = '{default: {DATA_BITS{1'b0}}};
    assign consumer_write_ready = {NUM_CONSUMERS{1'b0}};
`endif

endmodule
